// File: rtl/booth_pkg.sv
// Shared types and size helpers for the radix-4 Booth multiplier.
package booth_pkg;

  // Internal operand width: one guard bit for sign/zero extension plus one
  // so that the digit count is an integer.
  function automatic int booth_xw(input int width);
    return width + 32'sd2;
  endfunction

  // Number of radix-4 digits, one per CALC cycle.
  function automatic int booth_n(input int width);
    return (width + 32'sd2) / 32'sd2;
  endfunction

  // Recoded radix-4 Booth digit.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  // Control FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } booth_state_t;

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth digit decoder: maps a 3-bit multiplier window to a digit
// and the matching partial product (0, +-mcand, +-2*mcand), all modulo 2^PW.
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int PW = 18
) (
  input  logic [2:0]    bits,
  input  logic [PW-1:0] mcand,
  output booth_digit_t  digit,
  output logic [PW-1:0] pp
);

  localparam logic [PW-1:0] PP_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PP_ZERO = {PW{1'b0}};

  logic [PW-1:0] mcand_x2_s;

  // Doubled multiplicand used by the +-2 digits.
  always_comb begin
    mcand_x2_s = {mcand[PW-2:0], 1'b0};
  end

  // Decode the window into a digit and select the partial product.
  always_comb begin
    digit = ZERO;
    pp    = PP_ZERO;
    case (bits)
      3'b000, 3'b111: begin
        digit = ZERO;
        pp    = PP_ZERO;
      end
      3'b001, 3'b010: begin
        digit = POS1;
        pp    = mcand;
      end
      3'b011: begin
        digit = POS2;
        pp    = mcand_x2_s;
      end
      3'b100: begin
        digit = NEG2;
        pp    = (~mcand_x2_s) + PP_ONE;
      end
      3'b101, 3'b110: begin
        digit = NEG1;
        pp    = (~mcand) + PP_ONE;
      end
      default: begin
        digit = ZERO;
        pp    = PP_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/booth_multiplier_r4.sv
// Parametrised radix-4 Booth multiplier with start/busy/done handshake.
// Produces the full 2*WIDTH-bit product for signed or unsigned operands.
// Optional build macro BOOTH_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zeros or all ones (every later digit is zero).
module booth_multiplier_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int XW = booth_xw(WIDTH);
  localparam int N  = booth_n(WIDTH);
  localparam int PW = 2 * WIDTH + 2;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(N);

  // Architectural state
  booth_state_t         state_r;
  logic [PW-1:0]        acc_r;
  logic [PW-1:0]        mcand_r;
  logic [XW:0]          mplr_r;
  logic [CW-1:0]        cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   result_r;

  // Next-value and decode signals
  logic [XW-1:0]        m_ext_s;
  logic [XW-1:0]        q_ext_s;
  booth_digit_t         digit_s;
  logic [PW-1:0]        pp_s;
  logic [PW-1:0]        acc_next_s;
  logic [XW:0]          mplr_next_s;
  logic [CW-1:0]        cnt_next_s;
  logic                 early_s;
  logic                 finish_s;

  booth_r4_digit #(
    .PW (PW)
  ) u_digit (
    .bits  (mplr_r[2:0]),
    .mcand (mcand_r),
    .digit (digit_s),
    .pp    (pp_s)
  );

  // Extend the operands to XW bits according to the requested signedness.
  always_comb begin
    m_ext_s = {2'b00, M};
    q_ext_s = {2'b00, Q};
    if (signed_mode) begin
      m_ext_s = {{2{M[WIDTH-1]}}, M};
      q_ext_s = {{2{Q[WIDTH-1]}}, Q};
    end else begin
      m_ext_s = {2'b00, M};
      q_ext_s = {2'b00, Q};
    end
  end

  // Per-iteration datapath: accumulate, shift the multiplier window, count.
  always_comb begin
    acc_next_s  = acc_r;
    mplr_next_s = {{2{mplr_r[XW]}}, mplr_r[XW:2]};
    cnt_next_s  = cnt_r + CNT_ONE;
    if (digit_s == ZERO) begin
      acc_next_s = acc_r;
    end else begin
      acc_next_s = acc_r + pp_s;
    end
  end

  // Completion: last digit consumed, or remaining digits known to be zero.
  always_comb begin
    early_s  = 1'b0;
`ifdef BOOTH_EARLY_TERM_EN
    early_s  = (mplr_next_s == {(XW+1){1'b0}}) || (mplr_next_s == {(XW+1){1'b1}});
`else
    early_s  = 1'b0;
`endif
    finish_s = (cnt_next_s == CNT_LAST) || early_s;
  end

  // Control FSM with registered handshake outputs and product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      acc_r    <= {PW{1'b0}};
      mcand_r  <= {PW{1'b0}};
      mplr_r   <= {(XW+1){1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            acc_r   <= {PW{1'b0}};
            mcand_r <= {{WIDTH{m_ext_s[XW-1]}}, m_ext_s};
            mplr_r  <= {q_ext_s, 1'b0};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r   <= acc_next_s;
          mcand_r <= {mcand_r[PW-3:0], 2'b00};
          mplr_r  <= mplr_next_s;
          cnt_r   <= cnt_next_s;
          if (finish_s) begin
            result_r <= acc_next_s[2*WIDTH-1:0];
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end else begin
            done_r   <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= CALC;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_booth_multiplier_r4.sv
// Self-checking bench for booth_multiplier_r4: directed vectors on a WIDTH=8
// instance plus a random sweep over WIDTH=4/8/16 instances.
module tb_booth_multiplier_r4;

`ifdef BOOTH_EARLY_TERM_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  logic clk;
  logic rst;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  m8, q8;
  logic [15:0] res8;

  logic        start_sw, sm_sw;
  logic        busy4, done4, busy16, done16;
  logic [3:0]  m4, q4;
  logic [7:0]  res4;
  logic [15:0] m16, q16;
  logic [31:0] res16;

  int checks;
  int fails;

  booth_multiplier_r4 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .M(m8), .Q(q8), .busy(busy8), .done(done8), .result(res8)
  );

  booth_multiplier_r4 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_sw), .signed_mode(sm_sw),
    .M(m4), .Q(q4), .busy(busy4), .done(done4), .result(res4)
  );

  booth_multiplier_r4 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start_sw), .signed_mode(sm_sw),
    .M(m16), .Q(q16), .busy(busy16), .done(done16), .result(res16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one op on dut8; report cycles to done (-1 on timeout) and busy cycles.
  task automatic do_op8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    sm8 = sm; m8 = m; q8 = q; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    busy_cnt = busy8 ? 1 : 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = c;
        break;
      end
      if (busy8) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done8); end
    checks++; if (res8 !== 16'h0000) begin fails++; $display("FAIL reset_result got %h want 0000", res8); end
    checks++; if (res16 !== 32'h0) begin fails++; $display("FAIL reset_result16 got %h want 0", res16); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_signed_basic();
    int lat, bc;
    do_op8(1'b1, 8'hF8, 8'h02, lat, bc);
    checks++; if (res8 !== 16'hFFF0) begin fails++; $display("FAIL neg8x2_result got %h want fff0", res8); end
    checks++; if (lat != 5) begin fails++; $display("FAIL neg8x2_latency got %0d want 5", lat); end
    checks++; if (bc != 5) begin fails++; $display("FAIL neg8x2_busy_cycles got %0d want 5", bc); end
    checks++; if (busy8 !== 1'b0) begin fails++; $display("FAIL neg8x2_busy_at_done got %b want 0", busy8); end
    @(posedge clk); #1;
    checks++; if (done8 !== 1'b0) begin fails++; $display("FAIL neg8x2_done_pulse got %b want 0", done8); end
    checks++; if (res8 !== 16'hFFF0) begin fails++; $display("FAIL neg8x2_hold got %h want fff0", res8); end
  endtask

  task automatic test_extremes();
    int lat, bc;
    do_op8(1'b0, 8'd200, 8'd255, lat, bc);
    checks++; if (res8 !== 16'hC738) begin fails++; $display("FAIL u200x255_result got %h want c738", res8); end
    checks++; if (lat != 5) begin fails++; $display("FAIL u200x255_latency got %0d want 5", lat); end
    do_op8(1'b1, 8'h80, 8'h80, lat, bc);
    checks++; if (res8 !== 16'h4000) begin fails++; $display("FAIL s128x128_result got %h want 4000", res8); end
    checks++; if (lat < 1 || lat > 5) begin fails++; $display("FAIL s128x128_latency got %0d want 1..5", lat); end
    do_op8(1'b0, 8'd255, 8'd255, lat, bc);
    checks++; if (res8 !== 16'hFE01) begin fails++; $display("FAIL u255x255_result got %h want fe01", res8); end
    do_op8(1'b1, 8'h7F, 8'h80, lat, bc);
    checks++; if (res8 !== 16'hC080) begin fails++; $display("FAIL s127xm128_result got %h want c080", res8); end
  endtask

  task automatic test_early_term();
    int lat, bc;
    do_op8(1'b1, 8'd37, 8'd1, lat, bc);
    checks++; if (res8 !== 16'h0025) begin fails++; $display("FAIL et_q1_result got %h want 0025", res8); end
    checks++; if (lat != (EARLY ? 1 : 5)) begin fails++; $display("FAIL et_q1_latency got %0d want %0d", lat, EARLY ? 1 : 5); end
    do_op8(1'b1, 8'd37, 8'hFF, lat, bc);
    checks++; if (res8 !== 16'hFFDB) begin fails++; $display("FAIL et_qm1_result got %h want ffdb", res8); end
    checks++; if (lat != (EARLY ? 1 : 5)) begin fails++; $display("FAIL et_qm1_latency got %0d want %0d", lat, EARLY ? 1 : 5); end
    do_op8(1'b0, 8'd37, 8'd255, lat, bc);
    checks++; if (res8 !== 16'h24DB) begin fails++; $display("FAIL et_u255_result got %h want 24db", res8); end
    checks++; if (lat != 5) begin fails++; $display("FAIL et_u255_latency got %0d want 5", lat); end
  endtask

  task automatic test_back_to_back();
    int done_cnt, first_done, lat;
    @(negedge clk);
    sm8 = 1'b0; m8 = 8'd10; q8 = 8'd200; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk);
    m8 = 8'd3; q8 = 8'd3; start8 = 1'b1;
    done_cnt = 0; first_done = -1;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      if (j == 3) start8 = 1'b0;
      if (done8) begin
        done_cnt++;
        if (first_done < 0) first_done = j;
      end
    end
    checks++; if (first_done != 5) begin fails++; $display("FAIL held_start_done_at got %0d want 5", first_done); end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL held_start_done_count got %0d want 1", done_cnt); end
    checks++; if (res8 !== 16'h07D0) begin fails++; $display("FAIL held_start_result got %h want 07d0", res8); end
    // Still inside the done cycle: a fresh request must be accepted.
    sm8 = 1'b0; m8 = 8'd7; q8 = 8'd200; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++; if (busy8 !== 1'b1) begin fails++; $display("FAIL done_cycle_accept_busy got %b want 1", busy8); end
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done8) begin lat = c; break; end
    end
    checks++; if (lat != 5) begin fails++; $display("FAIL done_cycle_latency got %0d want 5", lat); end
    checks++; if (res8 !== 16'h0578) begin fails++; $display("FAIL done_cycle_result got %h want 0578", res8); end
  endtask

  task automatic test_reset_mid_op();
    int stray;
    @(negedge clk);
    sm8 = 1'b0; m8 = 8'd10; q8 = 8'd200; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy8 !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0) begin fails++; $display("FAIL midrst_done got %b want 0", done8); end
    checks++; if (res8 !== 16'h0000) begin fails++; $display("FAIL midrst_result got %h want 0000", res8); end
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done8 || busy8) stray++;
    end
    checks++; if (stray != 0) begin fails++; $display("FAIL midrst_no_done got %0d active cycles want 0", stray); end
  endtask

  task automatic test_sweep();
    int lat4, lat8, lat16;
    logic [7:0]  e4;
    logic [15:0] e8;
    logic [31:0] e16;
    for (int it = 0; it < 700; it++) begin
      @(negedge clk);
      sm_sw = 1'($urandom_range(0, 1));
      sm8 = sm_sw;
      m4 = 4'($urandom); q4 = 4'($urandom);
      m8 = 8'($urandom); q8 = 8'($urandom);
      m16 = 16'($urandom); q16 = 16'($urandom);
      if (it % 7 == 0) begin q8 = 8'hFF; q4 = 4'hF; q16 = 16'hFFFF; end
      if (it % 11 == 0) begin m8 = 8'h80; m4 = 4'h8; m16 = 16'h8000; end
      if (sm_sw) begin
        e4  = 8'(longint'($signed(m4)) * longint'($signed(q4)));
        e8  = 16'(longint'($signed(m8)) * longint'($signed(q8)));
        e16 = 32'(longint'($signed(m16)) * longint'($signed(q16)));
      end else begin
        e4  = 8'(longint'(m4) * longint'(q4));
        e8  = 16'(longint'(m8) * longint'(q8));
        e16 = 32'(longint'(m16) * longint'(q16));
      end
      start_sw = 1'b1; start8 = 1'b1;
      @(posedge clk); #1;
      start_sw = 1'b0; start8 = 1'b0;
      lat4 = 0; lat8 = 0; lat16 = 0;
      for (int c = 1; c <= 12; c++) begin
        @(posedge clk); #1;
        if (done4  && lat4  == 0) lat4  = c;
        if (done8  && lat8  == 0) lat8  = c;
        if (done16 && lat16 == 0) lat16 = c;
      end
      checks++; if (res4 !== e4) begin fails++; $display("FAIL sweep4_result it=%0d got %h want %h", it, res4, e4); end
      checks++; if (res8 !== e8) begin fails++; $display("FAIL sweep8_result it=%0d got %h want %h", it, res8, e8); end
      checks++; if (res16 !== e16) begin fails++; $display("FAIL sweep16_result it=%0d got %h want %h", it, res16, e16); end
      checks++; if (lat4 < 1 || lat4 > 3 || (!EARLY && lat4 != 3)) begin fails++; $display("FAIL sweep4_latency it=%0d got %0d want <=3", it, lat4); end
      checks++; if (lat8 < 1 || lat8 > 5 || (!EARLY && lat8 != 5)) begin fails++; $display("FAIL sweep8_latency it=%0d got %0d want <=5", it, lat8); end
      checks++; if (lat16 < 1 || lat16 > 9 || (!EARLY && lat16 != 9)) begin fails++; $display("FAIL sweep16_latency it=%0d got %0d want <=9", it, lat16); end
    end
  endtask

  // Test sequence
  initial begin
    checks = 0; fails = 0;
    rst = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; m8 = 8'h00; q8 = 8'h00;
    start_sw = 1'b0; sm_sw = 1'b0; m4 = 4'h0; q4 = 4'h0; m16 = 16'h0; q16 = 16'h0;
    test_reset();
    test_signed_basic();
    test_extremes();
    test_early_term();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
